// File: rtl/apb_arb_pkg.sv
// ============================================================
// apb_arb_pkg : shared types and width helpers for the APB master
// Revision: 1.0
// ============================================================
`default_nettype none

`ifndef NO_OF_SLAVE_ON_BUS
`define NO_OF_SLAVE_ON_BUS 4
`endif

package apb_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } state_e;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        logic [2:0]  prot;
        logic        write;
    } apb_req_t;

    // Width of an index into n items; never collapses to zero bits.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Decode field width: wide enough to represent n itself, so an index of
    // n or more is observable even when n is a power of two.
    function automatic int dec_w(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/apb_bus_master_arb_rr_arbiter.sv
// ============================================================
// rr_arbiter : one-hot round-robin grant starting at ptr
// Revision: 1.0
// ============================================================
`default_nettype none

module rr_arbiter
    import apb_arb_pkg::*;
#(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]          req,
    input  logic [idx_w(NUM_REQ)-1:0]   ptr,
    input  logic                        enable,
    output logic [NUM_REQ-1:0]          grant,
    output logic [idx_w(NUM_REQ)-1:0]   idx,
    output logic                        valid
);

    localparam int c_W = idx_w(NUM_REQ);

    logic [c_W-1:0] w_cand;

    always_comb begin : p_search
        grant  = '0;
        idx    = '0;
        valid  = 1'b0;
        w_cand = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_cand = c_W'((int'(ptr) + i) % NUM_REQ);
            if (enable && !valid && req[w_cand]) begin
                valid = 1'b1;
                idx   = w_cand;
                grant = NUM_REQ'(1) << w_cand;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/apb_bus_master_arb.sv
// ============================================================
// apb_bus_master_arb : round-robin multi-requester APB4 master
// Revision: 1.0
// ============================================================
`default_nettype none

module apb_bus_master_arb
    import apb_arb_pkg::*;
#(
    parameter int NUM_REQ     = 4,
    parameter int NUM_SLV     = `NO_OF_SLAVE_ON_BUS,
    parameter int DEC_LSB     = 12,
    parameter int TIMEOUT_CYC = 16
) (
    input  logic                   PCLK,
    input  logic                   PRESETn,
    input  logic [NUM_REQ-1:0]     req_valid,
    output logic [NUM_REQ-1:0]     req_ready,
    input  logic [NUM_REQ-1:0]     req_write,
    input  logic [NUM_REQ*32-1:0]  req_addr,
    input  logic [NUM_REQ*32-1:0]  req_wdata,
    input  logic [NUM_REQ*4-1:0]   req_strb,
    input  logic [NUM_REQ*3-1:0]   req_prot,
    output logic [NUM_REQ-1:0]     rsp_valid,
    output logic [31:0]            rsp_rdata,
    output logic                   rsp_err,
    output logic [31:0]            PADDR,
    output logic [2:0]             PPROT,
    output logic [NUM_SLV-1:0]     PSELx,
    output logic                   PWRITE,
    output logic                   PENABLE,
    output logic [31:0]            PWDATA,
    output logic [3:0]             PSTRB,
    input  logic                   PREADY,
    input  logic [31:0]            PRDATA,
    input  logic                   PSLVERR
);

    localparam int c_REQ_W = idx_w(NUM_REQ);
    localparam int c_DEC_W = dec_w(NUM_SLV);

    state_e               r_state,     w_state_nxt;
    logic [c_REQ_W-1:0]   r_ptr,       w_ptr_nxt;
    logic [c_REQ_W-1:0]   r_gidx,      w_gidx_nxt;
    apb_req_t             r_req,       w_req_nxt;
    logic [7:0]           r_cnt,       w_cnt_nxt;
    logic [NUM_SLV-1:0]   r_psel,      w_psel_nxt;
    logic                 r_penable,   w_penable_nxt;
    logic [NUM_REQ-1:0]   r_ready,     w_ready_nxt;
    logic [NUM_REQ-1:0]   r_rsp_valid, w_rsp_valid_nxt;
    logic [31:0]          r_rdata,     w_rdata_nxt;
    logic                 r_err,       w_err_nxt;

    logic [NUM_REQ-1:0]   w_grant;
    logic [c_REQ_W-1:0]   w_gidx;
    logic                 w_gnt_any;
    apb_req_t             w_sel;
    logic [c_DEC_W-1:0]   w_slv_idx;
    logic                 w_dec_err;
    logic [7:0]           w_cnt_inc;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_arb (
        .req    (req_valid),
        .ptr    (r_ptr),
        .enable (r_state == IDLE),
        .grant  (w_grant),
        .idx    (w_gidx),
        .valid  (w_gnt_any)
    );

    always_comb begin : p_req_mux
        w_sel = '0;
        for (int r = 0; r < NUM_REQ; r++) begin
            if (w_gidx == c_REQ_W'(r)) begin
                w_sel.addr  = req_addr[r*32 +: 32];
                w_sel.wdata = req_wdata[r*32 +: 32];
                w_sel.strb  = req_strb[r*4 +: 4];
                w_sel.prot  = req_prot[r*3 +: 3];
                w_sel.write = req_write[r];
            end
        end
        // Reads must present an all-zero PSTRB, so mask it once at latch time.
        if (!w_sel.write) begin
            w_sel.strb = 4'h0;
        end
    end

    assign w_slv_idx = w_sel.addr[DEC_LSB +: c_DEC_W];
    assign w_dec_err = (int'(w_slv_idx) >= NUM_SLV);
    assign w_cnt_inc = r_cnt + 8'd1;

    always_comb begin : p_fsm_next
        w_state_nxt     = r_state;
        w_ptr_nxt       = r_ptr;
        w_gidx_nxt      = r_gidx;
        w_req_nxt       = r_req;
        w_cnt_nxt       = r_cnt;
        w_psel_nxt      = r_psel;
        w_penable_nxt   = r_penable;
        w_ready_nxt     = '0;
        w_rsp_valid_nxt = '0;
        w_rdata_nxt     = r_rdata;
        w_err_nxt       = r_err;
        unique case (r_state)
            IDLE: begin
                if (w_gnt_any) begin
                    w_ready_nxt = w_grant;
                    w_req_nxt   = w_sel;
                    w_gidx_nxt  = w_gidx;
                    w_ptr_nxt   = (w_gidx == c_REQ_W'(NUM_REQ - 1)) ? '0
                                                                    : w_gidx + c_REQ_W'(1);
                    if (w_dec_err) begin
                        w_rsp_valid_nxt = w_grant;
                        w_rdata_nxt     = '0;
                        w_err_nxt       = 1'b1;
                        w_state_nxt     = RESP;
                    end else begin
                        w_psel_nxt  = NUM_SLV'(1) << w_slv_idx;
                        w_state_nxt = SETUP;
                    end
                end
            end
            SETUP: begin
                w_penable_nxt = 1'b1;
                w_cnt_nxt     = '0;
                w_state_nxt   = ACCESS;
            end
            ACCESS: begin
                // PREADY takes priority over a timeout landing in the same cycle.
                if (PREADY || (w_cnt_inc == 8'(TIMEOUT_CYC))) begin
                    w_rsp_valid_nxt = NUM_REQ'(1) << r_gidx;
                    w_rdata_nxt     = (PREADY && !r_req.write) ? PRDATA : 32'h0;
                    w_err_nxt       = PREADY ? PSLVERR : 1'b1;
                    w_psel_nxt      = '0;
                    w_penable_nxt   = 1'b0;
                    w_cnt_nxt       = '0;
                    w_state_nxt     = RESP;
                end else begin
                    w_cnt_nxt = w_cnt_inc;
                end
            end
            RESP: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin : p_fsm_reg
        if (!PRESETn) begin
            r_state     <= IDLE;
            r_ptr       <= '0;
            r_gidx      <= '0;
            r_req       <= '0;
            r_cnt       <= '0;
            r_psel      <= '0;
            r_penable   <= 1'b0;
            r_ready     <= '0;
            r_rsp_valid <= '0;
            r_rdata     <= '0;
            r_err       <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_ptr       <= w_ptr_nxt;
            r_gidx      <= w_gidx_nxt;
            r_req       <= w_req_nxt;
            r_cnt       <= w_cnt_nxt;
            r_psel      <= w_psel_nxt;
            r_penable   <= w_penable_nxt;
            r_ready     <= w_ready_nxt;
            r_rsp_valid <= w_rsp_valid_nxt;
            r_rdata     <= w_rdata_nxt;
            r_err       <= w_err_nxt;
        end
    end

    assign req_ready = r_ready;
    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_rdata;
    assign rsp_err   = r_err;
    assign PADDR     = r_req.addr;
    assign PWDATA    = r_req.wdata;
    assign PSTRB     = r_req.strb;
    assign PPROT     = r_req.prot;
    assign PWRITE    = r_req.write;
    assign PSELx     = r_psel;
    assign PENABLE   = r_penable;

endmodule

`default_nettype wire

// File: tb/tb_apb_bus_master_arb.sv
// ============================================================
// tb_apb_bus_master_arb : directed self-checking bench for the APB master
// Revision: 1.0
// ============================================================
`default_nettype none

module tb_apb_bus_master_arb;

    localparam int NR = 4;
    localparam int NS = 4;

    logic              PCLK = 1'b0;
    logic              PRESETn = 1'b0;
    logic [NR-1:0]     req_valid, req_ready, req_write, rsp_valid;
    logic [NR*32-1:0]  req_addr, req_wdata;
    logic [NR*4-1:0]   req_strb;
    logic [NR*3-1:0]   req_prot;
    logic [31:0]       rsp_rdata;
    logic              rsp_err;
    logic [31:0]       PADDR, PWDATA, PRDATA;
    logic [2:0]        PPROT;
    logic [NS-1:0]     PSELx;
    logic              PWRITE, PENABLE, PREADY, PSLVERR;
    logic [3:0]        PSTRB;

    int                checks = 0;
    int                errors = 0;
    int                cnt;
    int                ok;
    logic [NR-1:0]     v;
    logic [31:0]       rd;
    logic              e;

    always #5 PCLK = ~PCLK;

    apb_bus_master_arb #(
        .NUM_REQ     (NR),
        .NUM_SLV     (NS),
        .DEC_LSB     (12),
        .TIMEOUT_CYC (16)
    ) dut (
        .PCLK      (PCLK),
        .PRESETn   (PRESETn),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_strb  (req_strb),
        .req_prot  (req_prot),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .PADDR     (PADDR),
        .PPROT     (PPROT),
        .PSELx     (PSELx),
        .PWRITE    (PWRITE),
        .PENABLE   (PENABLE),
        .PWDATA    (PWDATA),
        .PSTRB     (PSTRB),
        .PREADY    (PREADY),
        .PRDATA    (PRDATA),
        .PSLVERR   (PSLVERR)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int r, input logic w, input logic [31:0] a,
                           input logic [31:0] d, input logic [3:0] s, input logic [2:0] p);
        req_write[r]        = w;
        req_addr[r*32 +: 32] = a;
        req_wdata[r*32 +: 32] = d;
        req_strb[r*4 +: 4]  = s;
        req_prot[r*3 +: 3]  = p;
        req_valid[r]        = 1'b1;
    endtask

    // Waits (bounded) for the accept pulse, then withdraws the request.
    task automatic wait_ready(input int r, output int got);
        got = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge PCLK);
            if (req_ready[r]) begin
                req_valid[r] = 1'b0;
                got = 1;
                break;
            end
        end
    endtask

    task automatic run_txn(input int r, input logic w, input logic [31:0] a,
                           input logic [31:0] d, output logic [NR-1:0] rv,
                           output logic [31:0] rdat, output logic rerr);
        int got;
        set_req(r, w, a, d, 4'hF, 3'b000);
        wait_ready(r, got);
        rv = '0; rdat = 'x; rerr = 1'bx;
        for (int i = 0; i < 40; i++) begin
            if (rsp_valid != '0) begin
                rv = rsp_valid; rdat = rsp_rdata; rerr = rsp_err;
                break;
            end
            @(negedge PCLK);
        end
    endtask

    initial begin
        req_valid = '0; req_write = '0; req_addr = '0; req_wdata = '0;
        req_strb = '0; req_prot = '0;
        PREADY = 1'b1; PRDATA = 32'h0; PSLVERR = 1'b0;

        // Reset state
        repeat (3) @(negedge PCLK);
        check("rst_psel",    32'(PSELx),     32'h0);
        check("rst_penable", 32'(PENABLE),   32'h0);
        check("rst_ready",   32'(req_ready), 32'h0);
        check("rst_rspv",    32'(rsp_valid), 32'h0);
        check("rst_paddr",   PADDR,          32'h0);
        PRESETn = 1'b1;
        @(negedge PCLK);

        // 1: single write, zero wait states
        set_req(0, 1'b1, 32'h0000_1004, 32'hDEAD_BEEF, 4'hF, 3'b010);
        @(negedge PCLK);
        check("t1_ready",   32'(req_ready), 32'h1);
        check("t1_psel",    32'(PSELx),     32'h2);
        check("t1_pen_su",  32'(PENABLE),   32'h0);
        check("t1_paddr",   PADDR,          32'h0000_1004);
        check("t1_pwdata",  PWDATA,         32'hDEAD_BEEF);
        check("t1_pstrb",   32'(PSTRB),     32'hF);
        check("t1_pwrite",  32'(PWRITE),    32'h1);
        check("t1_pprot",   32'(PPROT),     32'h2);
        req_valid[0] = 1'b0;
        @(negedge PCLK);
        check("t1_pen_ac",  32'(PENABLE),   32'h1);
        check("t1_psel_ac", 32'(PSELx),     32'h2);
        check("t1_paddr_h", PADDR,          32'h0000_1004);
        check("t1_rspv_no", 32'(rsp_valid), 32'h0);
        @(negedge PCLK);
        check("t1_rspv",    32'(rsp_valid), 32'h1);
        check("t1_err",     32'(rsp_err),   32'h0);
        check("t1_psel_off",32'(PSELx),     32'h0);
        check("t1_pen_off", 32'(PENABLE),   32'h0);
        @(negedge PCLK);
        check("t1_rspv_end",32'(rsp_valid), 32'h0);

        // 2: read with 3 wait states
        PREADY = 1'b0; PRDATA = 32'h1234_5678;
        set_req(2, 1'b0, 32'h0000_3000, 32'hAAAA_5555, 4'hF, 3'b000);
        @(negedge PCLK);
        check("t2_ready",  32'(req_ready), 32'h4);
        check("t2_psel",   32'(PSELx),     32'h8);
        check("t2_pstrb",  32'(PSTRB),     32'h0);
        check("t2_pwrite", 32'(PWRITE),    32'h0);
        req_valid[2] = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge PCLK);
            check("t2_penable", 32'(PENABLE), 32'h1);
            if (i == 3) PREADY = 1'b1;
        end
        @(negedge PCLK);
        check("t2_rspv",   32'(rsp_valid), 32'h4);
        check("t2_rdata",  rsp_rdata,      32'h1234_5678);
        check("t2_err",    32'(rsp_err),   32'h0);
        check("t2_pen_off",32'(PENABLE),   32'h0);
        @(negedge PCLK);

        // 3: all requesters continuously valid after reset
        PRESETn = 1'b0;
        @(negedge PCLK);
        PRESETn = 1'b1;
        for (int r = 0; r < NR; r++) set_req(r, 1'b1, 32'(r) << 12, 32'h100 + 32'(r), 4'hF, 3'b000);
        for (int k = 0; k < 5; k++) begin
            for (int i = 0; i < 8; i++) begin
                @(negedge PCLK);
                if (req_ready != '0) break;
            end
            check("t3_grant", 32'(req_ready), 32'h1 << (k % 4));
        end
        req_valid = '0;
        repeat (4) @(negedge PCLK);

        // 4: decode error (slave index 5 with 4 slaves)
        PRDATA = 32'hFFFF_0000;
        set_req(1, 1'b0, 32'h0000_5000, 32'h0, 4'h0, 3'b000);
        @(negedge PCLK);
        check("t4_ready", 32'(req_ready), 32'h2);
        check("t4_rspv",  32'(rsp_valid), 32'h2);
        check("t4_err",   32'(rsp_err),   32'h1);
        check("t4_rdata", rsp_rdata,      32'h0);
        check("t4_psel",  32'(PSELx),     32'h0);
        req_valid[1] = 1'b0;
        @(negedge PCLK);
        check("t4_rspv_end", 32'(rsp_valid), 32'h0);
        check("t4_psel_end", 32'(PSELx),     32'h0);

        // 5: PREADY timeout, then a normal transfer
        PREADY = 1'b0;
        set_req(3, 1'b1, 32'h0000_2000, 32'h1111_2222, 4'h3, 3'b000);
        @(negedge PCLK);
        check("t5_ready", 32'(req_ready), 32'h8);
        check("t5_psel",  32'(PSELx),     32'h4);
        req_valid[3] = 1'b0;
        cnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge PCLK);
            if (rsp_valid != '0) break;
            if (PENABLE && PSELx == 4'b0100) cnt++;
        end
        check("t5_access_cycles", 32'(cnt),   32'd16);
        check("t5_rspv",  32'(rsp_valid),     32'h8);
        check("t5_err",   32'(rsp_err),       32'h1);
        check("t5_rdata", rsp_rdata,          32'h0);
        check("t5_psel",  32'(PSELx),         32'h0);
        check("t5_pen",   32'(PENABLE),       32'h0);
        PREADY = 1'b1; PRDATA = 32'hCAFE_F00D;
        run_txn(0, 1'b0, 32'h0000_0010, 32'h0, v, rd, e);
        check("t5_next_rspv",  32'(v), 32'h1);
        check("t5_next_rdata", rd,     32'hCAFE_F00D);
        check("t5_next_err",   32'(e), 32'h0);

        // 6: slave error on a write, then reset during ACCESS
        PSLVERR = 1'b1;
        run_txn(1, 1'b1, 32'h0000_1008, 32'h5555_AAAA, v, rd, e);
        check("t6_rspv",  32'(v), 32'h2);
        check("t6_err",   32'(e), 32'h1);
        check("t6_rdata", rd,     32'h0);
        PSLVERR = 1'b0;
        PREADY  = 1'b0;
        set_req(2, 1'b1, 32'h0000_3004, 32'h7777_8888, 4'hF, 3'b001);
        wait_ready(2, ok);
        check("t6_granted", 32'(ok), 32'h1);
        @(negedge PCLK);
        check("t6_pen_ac", 32'(PENABLE), 32'h1);
        check("t6_psel_ac",32'(PSELx),   32'h8);
        #2 PRESETn = 1'b0;
        #1;
        check("t6_rst_psel",   32'(PSELx),     32'h0);
        check("t6_rst_pen",    32'(PENABLE),   32'h0);
        check("t6_rst_paddr",  PADDR,          32'h0);
        check("t6_rst_pwdata", PWDATA,         32'h0);
        check("t6_rst_pstrb",  32'(PSTRB),     32'h0);
        check("t6_rst_pwrite", 32'(PWRITE),    32'h0);
        check("t6_rst_rspv",   32'(rsp_valid), 32'h0);
        repeat (2) @(negedge PCLK);
        PRESETn = 1'b1;
        PREADY  = 1'b1;
        cnt = 0;
        repeat (6) begin
            @(negedge PCLK);
            if (rsp_valid != '0) cnt++;
        end
        check("t6_no_rsp", 32'(cnt), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
